// File: rtl/cacheline_adaptor_param.sv
// Bridges a single-cycle cache line port to a burst memory port of configurable
// width, supporting line read, line write and evict-then-fill with beat stalls.
module cacheline_adaptor_param #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic [ADDR_WIDTH-1:0]  evict_address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int CW     = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [LINE_WIDTH-1:0]   r_wr_shift;
  logic [LINE_WIDTH-1:0]   r_rd_shift;
  logic [ADDR_WIDTH-1:0]   r_fill_addr;
  logic                    r_fill_pending;

  logic                    w_last;
  logic [LINE_WIDTH-1:0]   w_rd_next;
  logic [LINE_WIDTH-1:0]   w_wr_next;

  // Write beats leave from the bottom; read beats enter at the top so beat 0 ends lowest.
  assign w_last    = (r_cnt == LAST_BEAT);
  assign w_rd_next = {burst_i, r_rd_shift[LINE_WIDTH-1:BURST_WIDTH]};
  assign w_wr_next = {{BURST_WIDTH{1'b0}}, r_wr_shift[LINE_WIDTH-1:BURST_WIDTH]};

  // Control FSM with all memory- and cache-side outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= {CW{1'b0}};
      r_wr_shift     <= {LINE_WIDTH{1'b0}};
      r_rd_shift     <= {LINE_WIDTH{1'b0}};
      r_fill_addr    <= {ADDR_WIDTH{1'b0}};
      r_fill_pending <= 1'b0;
      line_o         <= {LINE_WIDTH{1'b0}};
      burst_o        <= {BURST_WIDTH{1'b0}};
      address_o      <= {ADDR_WIDTH{1'b0}};
      read_o         <= 1'b0;
      write_o        <= 1'b0;
      resp_o         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt  <= {CW{1'b0}};
          resp_o <= 1'b0;
          if (write_i) begin
            r_state        <= S_WR;
            write_o        <= 1'b1;
            burst_o        <= line_i[BURST_WIDTH-1:0];
            r_wr_shift     <= {{BURST_WIDTH{1'b0}}, line_i[LINE_WIDTH-1:BURST_WIDTH]};
            r_fill_addr    <= address_i & ALIGN_MASK;
            r_fill_pending <= read_i;
            address_o      <= (read_i ? evict_address_i : address_i) & ALIGN_MASK;
          end else if (read_i) begin
            r_state        <= S_RD;
            read_o         <= 1'b1;
            r_fill_pending <= 1'b0;
            address_o      <= address_i & ALIGN_MASK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WR: begin
          if (resp_i) begin
            burst_o    <= r_wr_shift[BURST_WIDTH-1:0];
            r_wr_shift <= w_wr_next;
            if (w_last) begin
              r_cnt   <= {CW{1'b0}};
              write_o <= 1'b0;
              // Evict done: hand over straight to the fill with no idle gap.
              if (r_fill_pending) begin
                r_state        <= S_RD;
                read_o         <= 1'b1;
                address_o      <= r_fill_addr;
                r_fill_pending <= 1'b0;
              end else begin
                r_state <= S_DONE;
                resp_o  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_RD: begin
          if (resp_i) begin
            r_rd_shift <= w_rd_next;
            if (w_last) begin
              r_cnt   <= {CW{1'b0}};
              line_o  <= w_rd_next;
              read_o  <= 1'b0;
              resp_o  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_DONE: begin
          resp_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= {CW{1'b0}};
          read_o  <= 1'b0;
          write_o <= 1'b0;
          resp_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
